// File: rtl/vreg_operand_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vreg_operand_fetch                                            |
// | Function : Walks a vector of register rows, issues replicated read       |
// |            addresses to a banked register file and streams the returned  |
// |            operand pairs out under a valid/ready handshake.              |
// | Option   : VREG_FETCH_BGATE_EN - when defined, operand b is read only if |
// |            issue_use_b was set at issue; otherwise b is always read.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vreg_operand_fetch #(
    parameter int NUMBANKS           = 1,
    parameter int LOG2NUMREGSPERBANK = 5,
    parameter int WIDTH              = 32
) (
    input  logic                                   clk,
    input  logic                                   resetn,

    input  logic                                   issue_valid,
    output logic                                   issue_ready,
    input  logic [LOG2NUMREGSPERBANK-1:0]          issue_base_a,
    input  logic [LOG2NUMREGSPERBANK-1:0]          issue_base_b,
    input  logic [LOG2NUMREGSPERBANK:0]            issue_passes,
    input  logic                                   issue_use_b,

    output logic [NUMBANKS*LOG2NUMREGSPERBANK-1:0] a_reg,
    output logic [NUMBANKS*LOG2NUMREGSPERBANK-1:0] b_reg,
    output logic [NUMBANKS-1:0]                    a_en,
    output logic [NUMBANKS-1:0]                    b_en,
    input  logic [NUMBANKS*WIDTH-1:0]              a_readdatain,
    input  logic [NUMBANKS*WIDTH-1:0]              b_readdatain,

    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NUMBANKS*WIDTH-1:0]              out_a,
    output logic [NUMBANKS*WIDTH-1:0]              out_b,
    output logic                                   out_last,

    output logic                                   busy
);

    localparam int RW = LOG2NUMREGSPERBANK;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    localparam logic [RW:0] c_ONE  = {{RW{1'b0}}, 1'b1};
    localparam logic [RW:0] c_ZERO = '0;

    logic [1:0]    state_q, state_d;
    logic [RW:0]   p_q, p_d;
    logic [RW:0]   passes_q, passes_d;
    logic [RW-1:0] base_a_q, base_a_d;
    logic [RW-1:0] base_b_q, base_b_d;
    logic          out_valid_q, out_valid_d;
    logic          last_pending_q, last_pending_d;

    logic          w_accept;
    logic          w_advance;
    logic          w_final_pass;
    logic          w_last_taken;
    logic          w_b_read;
    logic [RW-1:0] w_row_a;
    logic [RW-1:0] w_row_b;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= c_ST_IDLE;
            p_q            <= '0;
            passes_q       <= '0;
            base_a_q       <= '0;
            base_b_q       <= '0;
            out_valid_q    <= 1'b0;
            last_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            p_q            <= p_d;
            passes_q       <= passes_d;
            base_a_q       <= base_a_d;
            base_b_q       <= base_b_d;
            out_valid_q    <= out_valid_d;
            last_pending_q <= last_pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                // A zero-length vector is accepted but never leaves IDLE.
                if (w_accept && (issue_passes != c_ZERO)) begin
                    state_d = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_advance && w_final_pass) begin
                    state_d = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_last_taken) begin
                    state_d = c_ST_IDLE;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        issue_ready  = (state_q == c_ST_IDLE);
        busy         = (state_q != c_ST_IDLE);
        w_accept     = issue_valid && (state_q == c_ST_IDLE);
        w_advance    = (state_q == c_ST_RUN) && (!out_valid_q || out_ready);
        w_final_pass = (p_q == (passes_q - c_ONE));
        out_valid    = out_valid_q;
        out_last     = out_valid_q && last_pending_q;
        w_last_taken = out_valid_q && out_ready && out_last;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_comb begin
        p_d            = p_q;
        passes_d       = passes_q;
        base_a_d       = base_a_q;
        base_b_d       = base_b_q;
        last_pending_d = last_pending_q;

        if (w_accept) begin
            p_d            = '0;
            passes_d       = issue_passes;
            base_a_d       = issue_base_a;
            base_b_d       = issue_base_b;
            last_pending_d = 1'b0;
        end

        if (w_advance) begin
            p_d = p_q + c_ONE;
            if (w_final_pass) begin
                last_pending_d = 1'b1;
            end
        end

        if (w_last_taken) begin
            last_pending_d = 1'b0;
        end

        // A held beat stays valid until it is taken.
        out_valid_d = w_advance || (out_valid_q && !out_ready);
    end

    // Row arithmetic is RW bits wide so the address wraps from the top row to 0.
    assign w_row_a = base_a_q + p_q[RW-1:0];
    assign w_row_b = base_b_q + p_q[RW-1:0];

`ifdef VREG_FETCH_BGATE_EN
    logic use_b_q, use_b_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            use_b_q <= 1'b0;
        end else begin
            use_b_q <= use_b_d;
        end
    end

    always_comb begin
        use_b_d = use_b_q;
        if (w_accept) begin
            use_b_d = issue_use_b;
        end
    end

    assign w_b_read = w_advance && use_b_q;
    assign out_b    = use_b_q ? b_readdatain : '0;
`else
    logic w_unused_use_b;

    assign w_unused_use_b = issue_use_b;
    assign w_b_read       = w_advance;
    assign out_b          = b_readdatain;
`endif

    assign out_a = a_readdatain;

    generate
        for (genvar g = 0; g < NUMBANKS; g++) begin : g_bank
            assign a_reg[g*RW +: RW] = w_row_a;
            assign b_reg[g*RW +: RW] = w_row_b;
            assign a_en[g]           = w_advance;
            assign b_en[g]           = w_b_read;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/vreg_operand_fetch.md
VREG_OPERAND_FETCH -- requirements
Module: vreg_operand_fetch

Interface
REQ-001 SHALL have parameter NUMBANKS, default 1: number of register-file banks, and lanes per pass.
REQ-002 SHALL have parameter LOG2NUMREGSPERBANK, default 5: row-address width per bank.
REQ-003 SHALL have parameter WIDTH, default 32: element width.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports issue_valid (input, 1) and issue_ready (output, 1): the issue handshake.
REQ-007 SHALL have ports issue_base_a and issue_base_b, input, LOG2NUMREGSPERBANK each: starting rows of the two operands.
REQ-008 SHALL have port issue_passes, input, LOG2NUMREGSPERBANK+1: number of rows to read, 0 allowed.
REQ-009 SHALL have port issue_use_b, input, 1: operand-b request flag; used only under the macro in REQ-027.
REQ-010 SHALL have ports a_reg and b_reg, output, NUMBANKS*LOG2NUMREGSPERBANK: the same row replicated into every bank field.
REQ-011 SHALL have ports a_en and b_en, output, NUMBANKS: the read enables, replicated across all banks.
REQ-012 SHALL have ports a_readdatain and b_readdatain, input, NUMBANKS*WIDTH: register-file read data, valid the cycle after an enabled address.
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_a and out_b (output, NUMBANKS*WIDTH each) and out_last (output, 1): the operand stream.
REQ-014 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-015 SHALL implement the states IDLE, RUN and DRAIN, with issue_ready=1 only in IDLE.
REQ-016 SHALL, on issue_valid & issue_ready, latch the bases and the pass count, clear the pass counter p, and go to RUN; if passes=0, SHALL stay in IDLE and produce no output.
REQ-017 SHALL define advance = (state==RUN) & (!out_valid | out_ready), combinationally.
REQ-018 SHALL drive a_en = b_en = advance on all bits, and a_reg = base_a+p and b_reg = base_b+p, each modulo 2^LOG2NUMREGSPERBANK, so the address wraps from the top row to row 0.
REQ-019 SHALL, while stalled (out_valid & !out_ready), hold the enables low so the register file keeps its previous q; the addresses SHALL remain stable.
REQ-020 SHALL, on advance, increment p, and if p==passes-1 go to DRAIN and register last_pending=1.
REQ-021 SHALL, on each clock edge, set out_valid to 1 if advance, otherwise to out_valid & !out_ready.
REQ-022 SHALL drive out_a and out_b directly from a_readdatain and b_readdatain, with zero added cycles.
REQ-023 SHALL assert out_last together with out_valid for the final pass only.
REQ-024 SHALL, in DRAIN, return to IDLE on the edge where out_valid & out_ready & out_last; issue_ready is therefore high the following cycle.
REQ-025 SHALL meet these latencies: acceptance at edge T0, first enable during cycle T0+1, first out_valid during cycle T0+2; throughput is one pass per cycle when out_ready=1.

Reset
REQ-026 SHALL, while resetn=0, asynchronously force state=IDLE, p=0, out_valid=0, last_pending=0 and the latched bases and count to 0; as a result a_en=b_en=0, busy=0, issue_ready=1 and out_last=0, and any in-flight vector is abandoned with no output.

Configuration
REQ-027 SHALL support macro VREG_FETCH_BGATE_EN: when defined, issue_use_b is latched at issue; if it is 0, b_en stays 0 for the whole vector and out_b is driven to 0. When the macro is undefined, issue_use_b is ignored and b is always read.

Verification
REQ-028 SHALL verify issue base_a=3, base_b=10, passes=4, out_ready=1 -> a_reg rows 3,4,5,6 on consecutive cycles; out_valid on 4 consecutive cycles; out_last on the 4th; issue_ready high again 1 cycle after the last output.
REQ-029 SHALL verify out_ready low for 3 cycles mid-vector -> en=0 and the addresses held; out_a held at the same value; no pass lost or duplicated.
REQ-030 SHALL verify base_a=30, passes=4, LOG2NUMREGSPERBANK=5 -> a_reg sequence 30,31,0,1.
REQ-031 SHALL verify passes=0 -> no enable and no out_valid; issue_ready high the next cycle.
REQ-032 SHALL verify resetn pulsed low during pass 2 -> out_valid, busy and enables 0 immediately; the next issue runs from its own base.
REQ-033 SHALL verify, with VREG_FETCH_BGATE_EN defined and use_b=0 -> b_en never asserted and out_b=0; with the macro undefined -> b_en follows a_en.
